// File: rtl/npu_job_sequencer_if.sv
// Write-channel, PE control and status signals of the NPU job sequencer.
// master = packet source / PE side, slave = the sequencer.
interface npu_job_sequencer_if #(
  parameter int RD_CH = 2
);
  logic             wr_sop_weight, wr_eop_weight, wr_vld_weight, err_weight;
  logic             wr_sop_data,   wr_eop_data,   wr_vld_data,   err_data;
  logic             clear;
  logic [RD_CH-1:0] rd_sop;
  logic             rd_eop;
  logic             save_sop, save_finish, busy, timeout_err;

  modport master (
    output wr_sop_weight, wr_eop_weight, wr_vld_weight,
           wr_sop_data, wr_eop_data, wr_vld_data, rd_eop,
    input  err_weight, err_data, clear, rd_sop,
           save_sop, save_finish, busy, timeout_err
  );

  modport slave (
    input  wr_sop_weight, wr_eop_weight, wr_vld_weight,
           wr_sop_data, wr_eop_data, wr_vld_data, rd_eop,
    output err_weight, err_data, clear, rd_sop,
           save_sop, save_finish, busy, timeout_err
  );
endinterface

// File: rtl/npu_job_sequencer.sv
// NPU job sequencer: per-channel packet length check, job-set counting and the
// EXEC/SAVE/WAIT/DONE job FSM. Define NPU_WAIT_TIMEOUT_EN to bound the WAIT state.

// One write channel: frames sop..eop, counts vld beats, flags good/bad packets.
module npu_pkt_chk #(
  parameter int LEN = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sop_i,
  input  logic eop_i,
  input  logic vld_i,
  output logic good_o,
  output logic err_o
);
  localparam int            LW    = $clog2(LEN + 2);
  localparam logic [LW-1:0] LEN_V = LW'(LEN);
  localparam logic [LW-1:0] OVF_V = LW'(LEN + 1);

  logic          open_q, open_d;
  logic          err_q, err_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] base, cur;

  // Beat count sticks at LEN+1 so an overlong packet can never wrap back to LEN.
  always_comb begin
    base   = sop_i ? '0 : len_q;
    cur    = (vld_i && base != OVF_V) ? base + LW'(1) : base;
    open_d = open_q;
    len_d  = len_q;
    good_o = 1'b0;
    err_d  = sop_i && open_q;
    if (eop_i) begin
      open_d = 1'b0;
      len_d  = '0;
      if ((sop_i || open_q) && cur == LEN_V) good_o = 1'b1;
      else                                   err_d  = 1'b1;
    end else if (sop_i || open_q) begin
      open_d = 1'b1;
      len_d  = cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= 1'b0;
      len_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      open_q <= open_d;
      len_q  <= len_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
endmodule

module npu_job_sequencer #(
  parameter int DATA_PKTS   = 3,
  parameter int WEIGHT_PKTS = 1,
  parameter int DATA_LEN    = 10,
  parameter int WEIGHT_LEN  = 36,
  parameter int COMPUTE_CYC = 24,
  parameter int RD_CH       = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input logic                 clk,
  input logic                 rst_n,
  npu_job_sequencer_if.slave  job_if
);
  localparam int DCW = $clog2(DATA_PKTS + 1);
  localparam int WCW = $clog2(WEIGHT_PKTS + 1);
  localparam int ECW = $clog2(COMPUTE_CYC + 1);

  if (DATA_PKTS < 1 || WEIGHT_PKTS < 1 || DATA_LEN < 1 || WEIGHT_LEN < 1 ||
      COMPUTE_CYC < 1 || RD_CH < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("npu_job_sequencer: all parameters must be >= 1");
  end

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    EXEC = 5'b00010,
    SAVE = 5'b00100,
    WAIT = 5'b01000,
    DONE = 5'b10000
  } state_e;

  state_e         state_q, state_d;
  logic [ECW-1:0] exec_cnt_q, exec_cnt_d;
  logic [DCW-1:0] data_cnt_q, data_cnt_d;
  logic [WCW-1:0] wt_cnt_q, wt_cnt_d;
  logic           good_data, good_wt, err_data, err_wt;
  logic           data_full, wt_full, job_start;
  logic           clear_q, clear_d, save_sop_q, save_sop_d;
  logic           save_fin_q, save_fin_d, busy_q, busy_d;
`ifdef NPU_WAIT_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           tmo_hit, tmo_q;
`endif

  npu_pkt_chk #(.LEN(DATA_LEN)) u_chk_data (
    .clk    (clk),
    .rst_n  (rst_n),
    .sop_i  (job_if.wr_sop_data),
    .eop_i  (job_if.wr_eop_data),
    .vld_i  (job_if.wr_vld_data),
    .good_o (good_data),
    .err_o  (err_data)
  );

  npu_pkt_chk #(.LEN(WEIGHT_LEN)) u_chk_wt (
    .clk    (clk),
    .rst_n  (rst_n),
    .sop_i  (job_if.wr_sop_weight),
    .eop_i  (job_if.wr_eop_weight),
    .vld_i  (job_if.wr_vld_weight),
    .good_o (good_wt),
    .err_o  (err_wt)
  );

  // Job-set counters: saturate when full, reload with the same-cycle good eop on job start.
  assign data_full = (data_cnt_q == DCW'(DATA_PKTS));
  assign wt_full   = (wt_cnt_q == WCW'(WEIGHT_PKTS));
  assign job_start = (state_q == IDLE) && data_full && wt_full;

  always_comb begin
    data_cnt_d = data_cnt_q;
    wt_cnt_d   = wt_cnt_q;
    if (job_start)                   data_cnt_d = DCW'(good_data);
    else if (good_data && !data_full) data_cnt_d = data_cnt_q + DCW'(1);
    if (job_start)                   wt_cnt_d   = WCW'(good_wt);
    else if (good_wt && !wt_full)     wt_cnt_d   = wt_cnt_q + WCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef NPU_WAIT_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (job_start) state_d = EXEC;
      EXEC: if (exec_cnt_q == ECW'(COMPUTE_CYC - 1)) state_d = SAVE;
      SAVE: state_d = WAIT;
      WAIT: begin
        if (job_if.rd_eop) state_d = DONE;
`ifdef NPU_WAIT_TIMEOUT_EN
        else if (wait_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
          state_d = DONE;
          tmo_hit = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pulse lines up with its state.
  always_comb begin
    clear_d    = (state_d == EXEC) && (state_q != EXEC);
    save_sop_d = (state_d == SAVE);
    save_fin_d = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    exec_cnt_d = (state_q == EXEC) ? exec_cnt_q + ECW'(1) : '0;
`ifdef NPU_WAIT_TIMEOUT_EN
    wait_cnt_d = (state_q == WAIT) ? wait_cnt_q + TCW'(1) : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt_q <= '0;
      data_cnt_q <= '0;
      wt_cnt_q   <= '0;
      clear_q    <= 1'b0;
      save_sop_q <= 1'b0;
      save_fin_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      exec_cnt_q <= exec_cnt_d;
      data_cnt_q <= data_cnt_d;
      wt_cnt_q   <= wt_cnt_d;
      clear_q    <= clear_d;
      save_sop_q <= save_sop_d;
      save_fin_q <= save_fin_d;
      busy_q     <= busy_d;
    end
  end

`ifdef NPU_WAIT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_q      <= tmo_hit;
    end
  end
  assign job_if.timeout_err = tmo_q;
`else
  assign job_if.timeout_err = 1'b0;
`endif

  assign job_if.err_data    = err_data;
  assign job_if.err_weight  = err_wt;
  assign job_if.clear       = clear_q;
  assign job_if.rd_sop      = {RD_CH{clear_q}};
  assign job_if.save_sop    = save_sop_q;
  assign job_if.save_finish = save_fin_q;
  assign job_if.busy        = busy_q;
endmodule
